// File: rtl/rotate_shift_engine_if.sv
// Command/data bundle for rotate_shift_engine: direct load/ena controls, command
// fields, and register/status outputs. master drives commands, slave is the engine.
interface rotate_shift_engine_if #(
  parameter int WIDTH = 100,
  parameter int AMT_W = 8
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic [1:0]       ena;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output load, data, ena, start, dir, mode, amount,
    input  q, busy, done
  );

  modport slave (
    input  load, data, ena, start, dir, mode, amount,
    output q, busy, done
  );
endinterface

// File: rtl/rotate_shift_engine.sv
// Wide register with single-step rotate plus commanded rotate/shift moving up to STEP bits per cycle.
// Latency ceil(amount/STEP) RUN cycles then a done pulse; no backpressure, start is ignored while busy.
module rotate_shift_engine #(
  parameter int WIDTH = 100,
  parameter int AMT_W = 8,
  parameter int STEP  = 1
) (
  input logic                  clk,
  input logic                  areset,
  rotate_shift_engine_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt, moved;
  logic [AMT_W-1:0] counter, counter_nxt, step_n;
  logic             cmd_dir, cmd_dir_nxt;
  logic [1:0]       cmd_mode, cmd_mode_nxt;
  logic             done, done_nxt;

  // Positions moved this RUN cycle; the STEP branch is only taken when STEP <= counter, so it fits AMT_W.
  always_comb begin
    step_n = AMT_W'(STEP);
    if (32'(counter) < 32'(STEP)) step_n = counter;
  end

  always_comb begin
    moved = q;
    if (cmd_mode == 2'b01 || (cmd_mode == 2'b10 && cmd_dir)) begin
      moved = cmd_dir ? (q << step_n) : (q >> step_n);
    end else if (cmd_mode == 2'b10) begin
      moved = $signed(q) >>> step_n;
    end else if (cmd_dir) begin
      moved = (q << step_n) | (q >> (32'(WIDTH) - 32'(step_n)));
    end else begin
      moved = (q >> step_n) | (q << (32'(WIDTH) - 32'(step_n)));
    end
  end

  always_comb begin
    state_nxt    = state;
    q_nxt        = q;
    counter_nxt  = counter;
    cmd_dir_nxt  = cmd_dir;
    cmd_mode_nxt = cmd_mode;
    done_nxt     = 1'b0;
    if (bus.load) begin
      q_nxt       = bus.data;
      state_nxt   = IDLE;
      counter_nxt = '0;
    end else if (state == IDLE && bus.start) begin
      if (bus.amount != '0) begin
        cmd_dir_nxt  = bus.dir;
        cmd_mode_nxt = bus.mode;
        counter_nxt  = bus.amount;
        state_nxt    = RUN;
      end else begin
        done_nxt = 1'b1;
      end
    end else if (state == RUN) begin
      q_nxt       = moved;
      counter_nxt = counter - step_n;
      if (counter_nxt == '0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end else begin
      case (bus.ena)
        2'b01:   q_nxt = {q[0], q[WIDTH-1:1]};
        2'b10:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      q        <= '0;
      counter  <= '0;
      cmd_dir  <= 1'b0;
      cmd_mode <= 2'b00;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      counter  <= counter_nxt;
      cmd_dir  <= cmd_dir_nxt;
      cmd_mode <= cmd_mode_nxt;
      done     <= done_nxt;
    end
  end

  assign bus.q    = q;
  assign bus.busy = (state == RUN);
  assign bus.done = done;

endmodule

// File: tb/tb_rotate_shift_engine.sv
// Bench for rotate_shift_engine at WIDTH=8, AMT_W=4 with STEP=3 (main) and STEP=1 (second instance).
module tb_rotate_shift_engine;
  localparam int W  = 8;
  localparam int AW = 4;

  logic clk    = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  rotate_shift_engine_if #(.WIDTH(W), .AMT_W(AW)) bus ();
  rotate_shift_engine_if #(.WIDTH(W), .AMT_W(AW)) bus1 ();

  rotate_shift_engine #(.WIDTH(W), .AMT_W(AW), .STEP(3)) u_dut (
    .clk(clk), .areset(areset), .bus(bus)
  );
  rotate_shift_engine #(.WIDTH(W), .AMT_W(AW), .STEP(1)) u_dut1 (
    .clk(clk), .areset(areset), .bus(bus1)
  );

  int passed = 0;
  int total  = 0;
  logic [7:0] model_q;
  logic [7:0] exp_q[$];

  // Reference: apply the command one position at a time.
  function automatic logic [7:0] model(input logic [7:0] v, input logic d, input logic [1:0] m, input int a);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < a; i++) begin
      case (m)
        2'b01:   r = d ? {r[6:0], 1'b0} : {1'b0, r[7:1]};
        2'b10:   r = d ? {r[6:0], 1'b0} : {r[7], r[7:1]};
        default: r = d ? {r[6:0], r[7]} : {r[0], r[7:1]};
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    bus.load = 1'b1;
    bus.data = d;
    tick();
    bus.load = 1'b0;
    model_q  = d;
  endtask

  task automatic issue(input logic d, input logic [1:0] m, input logic [3:0] a);
    bus.start  = 1'b1;
    bus.dir    = d;
    bus.mode   = m;
    bus.amount = a;
    tick();
    bus.start  = 1'b0;
    model_q    = model(model_q, d, m, int'(a));
    exp_q.push_back(model_q);
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (bus.busy === 1'b1) cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    #2 areset = 1'b1;
    #1;
    total++; if (bus.q !== 8'h00) $display("FAIL reset_q q=%h want 00", bus.q); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done); else passed++;
    @(posedge clk);
    #1 areset = 1'b0;
    do_load(8'h01);
    total++; if (bus.q !== 8'h01) $display("FAIL legacy_load q=%h want 01", bus.q); else passed++;
    bus.ena = 2'b01; tick();
    total++; if (bus.q !== 8'h80) $display("FAIL ena_right q=%h want 80", bus.q); else passed++;
    bus.ena = 2'b10; tick();
    total++; if (bus.q !== 8'h01) $display("FAIL ena_left q=%h want 01", bus.q); else passed++;
    bus.ena = 2'b11; tick();
    bus.ena = 2'b00;
    total++; if (bus.q !== 8'h01) $display("FAIL ena_hold q=%h want 01", bus.q); else passed++;
  endtask

  task automatic test_rotate();
    logic [7:0] e;
    do_load(8'h01);
    issue(1'b1, 2'b00, 4'd5);
    total++; if (bus.busy !== 1'b1 || bus.q !== 8'h01)
      $display("FAIL rot_t0 busy=%b q=%h want 1 01", bus.busy, bus.q); else passed++;
    bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b01; bus.amount = 4'd1;
    tick();
    total++; if (bus.q !== 8'h08 || bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL rot_mid q=%h busy=%b done=%b want 08 1 0", bus.q, bus.busy, bus.done); else passed++;
    tick();
    bus.start = 1'b0;
    e = exp_q.pop_front();
    total++; if (bus.q !== e || bus.busy !== 1'b0 || bus.done !== 1'b1)
      $display("FAIL rot_final q=%h busy=%b done=%b want %h 0 1", bus.q, bus.busy, bus.done, e); else passed++;
    tick();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== model_q)
      $display("FAIL rot_after q=%h busy=%b done=%b want %h 0 0", bus.q, bus.busy, bus.done, model_q); else passed++;
  endtask

  task automatic test_shifts();
    logic [7:0] tdat[4] = '{8'h90, 8'h90, 8'hFF, 8'h81};
    logic       tdir[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] tmod[4] = '{2'b10, 2'b01, 2'b01, 2'b00};
    logic [3:0] tamt[4] = '{4'd4, 4'd4, 4'd10, 4'd9};
    logic [7:0] e;
    int cyc;
    bit to;
    for (int k = 0; k < 4; k++) begin
      do_load(tdat[k]);
      issue(tdir[k], tmod[k], tamt[k]);
      wait_done(cyc, to);
      e = exp_q.pop_front();
      total++; if (to || bus.q !== e)
        $display("FAIL shift_%0d q=%h timeout=%0d want %h", k, bus.q, to, e); else passed++;
      total++; if (cyc != (int'(tamt[k]) + 2) / 3)
        $display("FAIL shift_cyc_%0d busy_cycles=%0d want %0d", k, cyc, (int'(tamt[k]) + 2) / 3); else passed++;
    end
  endtask

  task automatic test_zero_b2b();
    logic [7:0] e;
    int cyc;
    bit to;
    do_load(8'h3C);
    issue(1'b1, 2'b00, 4'd0);
    e = exp_q.pop_front();
    total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== e)
      $display("FAIL zero_amt done=%b busy=%b q=%h want 1 0 %h", bus.done, bus.busy, bus.q, e); else passed++;
    tick();
    total++; if (bus.done !== 1'b0) $display("FAIL zero_done_len done=%b want 0", bus.done); else passed++;
    issue(1'b1, 2'b00, 4'd2);
    wait_done(cyc, to);
    e = exp_q.pop_front();
    total++; if (to || bus.q !== e) $display("FAIL b2b_first q=%h timeout=%0d want %h", bus.q, to, e); else passed++;
    issue(1'b1, 2'b00, 4'd1);
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept busy=%b want 1", bus.busy); else passed++;
    wait_done(cyc, to);
    e = exp_q.pop_front();
    total++; if (to || bus.q !== e || cyc != 1)
      $display("FAIL b2b_second q=%h cycles=%0d want %h 1", bus.q, cyc, e); else passed++;
  endtask

  task automatic test_abort();
    bit seen;
    do_load(8'h01);
    issue(1'b1, 2'b00, 4'd7);
    exp_q.delete();
    tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL abort_pre busy=%b want 1", bus.busy); else passed++;
    do_load(8'h5A);
    total++; if (bus.q !== 8'h5A || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL abort q=%h busy=%b done=%b want 5a 0 0", bus.q, bus.busy, bus.done); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL abort_quiet done/busy seen=%b want 0", seen); else passed++;
    bus.ena = 2'b01; tick(); bus.ena = 2'b00;
    model_q = model(model_q, 1'b0, 2'b00, 1);
    total++; if (bus.q !== model_q) $display("FAIL abort_ena q=%h want %h", bus.q, model_q); else passed++;
  endtask

  task automatic test_async_reset();
    int cyc;
    bit to;
    do_load(8'h01);
    issue(1'b1, 2'b00, 4'd7);
    tick();
    #2 areset = 1'b1;
    #1;
    total++; if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL async_rst q=%h busy=%b done=%b want 00 0 0", bus.q, bus.busy, bus.done); else passed++;
    exp_q.delete();
    model_q = 8'h00;
    @(posedge clk);
    #1 areset = 1'b0;
    bus1.load = 1'b1; bus1.data = 8'h01; tick(); bus1.load = 1'b0;
    bus1.start = 1'b1; bus1.dir = 1'b1; bus1.mode = 2'b00; bus1.amount = 4'd3;
    tick();
    bus1.start = 1'b0;
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus1.done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (bus1.busy === 1'b1) cyc++;
      tick();
    end
    total++; if (to || cyc != 3) $display("FAIL step1_cycles busy_cycles=%0d timeout=%0d want 3", cyc, to); else passed++;
    total++; if (bus1.q !== model(8'h01, 1'b1, 2'b00, 3))
      $display("FAIL step1_q q=%h want %h", bus1.q, model(8'h01, 1'b1, 2'b00, 3)); else passed++;
  endtask

  initial begin
    bus.load = 1'b0;  bus.data = '0;  bus.ena = 2'b00;  bus.start = 1'b0;
    bus.dir = 1'b0;   bus.mode = 2'b00; bus.amount = '0;
    bus1.load = 1'b0; bus1.data = '0; bus1.ena = 2'b00; bus1.start = 1'b0;
    bus1.dir = 1'b0;  bus1.mode = 2'b00; bus1.amount = '0;
    model_q = 8'h00;
    test_reset();
    test_rotate();
    test_shifts();
    test_zero_b2b();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rotate_shift_engine.md
# rotate_shift_engine

Parametrised successor to the team's 100-bit single-step rotator. It keeps the direct load/ena one-position rotate path. It adds a commanded multi-position operation: rotate, logical shift or arithmetic shift by a programmable amount. The operation executes over several cycles at up to STEP positions per cycle, with busy/done handshaking. It sits in the datapath wherever a wide register needs controlled bit movement without a full-width barrel shifter.

## Interface
- WIDTH, 100, register width in bits (≥ 2)
- AMT_W, 8, width of the amount field
- STEP, 1, maximum positions moved per RUN cycle (1 ≤ STEP ≤ WIDTH)

- clk  input  1  clock; all state updates on its rising edge
- areset  input  1  reset, asynchronous, active-high
- load  input  1  synchronous load of data into q
- data  input  WIDTH  load value
- ena  input  2  direct single-step rotate when idle: 01 right, 10 left, 00/11 hold
- start  input  1  command strobe, sampled only in IDLE
- dir  input  1  command direction: 0 right, 1 left
- mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 treated as rotate
- amount  input  AMT_W  number of positions to move
- q  output  WIDTH  register contents
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse

## Operation
- Reset: q=0, busy=0, done=0, state IDLE, counter=0. Reset is applied immediately, without waiting for clk, including mid-RUN.
- States are IDLE and RUN. busy is the registered state (RUN=1).
- Per-edge priority: load > start (IDLE only) > RUN step > ena (IDLE only).
- load: q ← data, state ← IDLE, counter ← 0, done ← 0. This applies in any state; a RUN in progress is aborted with no done pulse.
- start in IDLE with amount ≠ 0: latch dir, mode and amount into command registers, counter ← amount, state ← RUN. q is unchanged on this edge.
- start in IDLE with amount = 0: done ← 1 for one cycle, state stays IDLE, q unchanged.
- start while RUN: ignored. dir, mode and amount are only sampled at start.
- RUN edge: s = min(STEP, counter). Move q by s positions using the latched dir and mode, and set counter ← counter − s.
  - If counter − s = 0: state ← IDLE, done ← 1.
- Movement rules (s positions):
  - Rotate: bits wrap around. Right moves q[0] toward the MSB end, i.e. for s=1, q ← {q[0], q[WIDTH-1:1]}.
  - Logical shift: zeros fill the vacated bits.
  - Arithmetic right: the MSB is replicated into the vacated bits.
  - Arithmetic left: identical to logical left.
- amount ≥ WIDTH is legal and is not reduced:
  - Rotate wraps modulo WIDTH.
  - Logical shift yields all zeros.
  - Arithmetic right yields all copies of the MSB.
- ena in IDLE, with no load or start: 01 gives q ← {q[0], q[WIDTH-1:1]}; 10 gives q ← {q[WIDTH-2:0], q[WIDTH-1]}. ena is ignored in RUN.
- done is 0 in every cycle except the single cycle after a completion edge.

## Timing
- Start edge is T0.
- A command of amount A takes N = ceil(A/STEP) RUN edges, T1..TN.
- busy is high in the cycles after T0 through TN, then falls.
- done is high for exactly the one cycle after TN. q holds the final value from TN onward.
- amount = 0: done is high in the cycle after T0; busy never rises.
- A new start is accepted on the edge after TN, when busy=0 and done=1. Back-to-back commands therefore have no dead cycle.
- load takes effect on the next edge; busy is 0 in the following cycle.

## Test plan
All scenarios use WIDTH=8, AMT_W=4, STEP=3 unless noted.
- Reset/legacy: assert areset → q=00, busy=0, done=0 with no clock edge. Then load=1 with data=01 → q=01. ena=01 for one edge → q=80. ena=10 for one edge → q=01. ena=11 → q holds.
- Multi-step rotate: q=01, start with dir=1, mode=00, amount=5 → busy high for 2 cycles, intermediate q=08, final q=20, done pulses once. start asserted again while busy changes nothing.
- Shifts: q=90, arithmetic right by 4 → q=F9 after 2 RUN cycles. Repeat with logical right by 4 → q=09. q=FF, logical left by 10 → q=00 after 4 cycles. q=81, rotate right by 9 → q=C0.
- Zero amount and back-to-back: start with amount=0 → done high the next cycle, busy stays 0, q unchanged. Then, a start issued in the done cycle of a previous command is accepted with no gap.
- Abort: assert load with data=5A during the 2nd RUN cycle → q=5A, busy=0 next cycle, done never pulses, ena works again afterwards.
- Async reset mid-RUN: assert areset between edges → q=00 and busy=0 immediately. After release, start with amount=3 and STEP=1 → exactly 3 busy cycles.
